// File: rtl/control_fsm.sv
// Multi-cycle control unit: fetch/decode/execute sequencer for a small
// RV32I subset (R-type ALU ops, addi, lw, sw, beq). It owns the
// instruction register and the latched decode fields, and it counts
// retired instructions.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  output logic [3:0]  estado,
  output logic        alusrc,
  output logic [3:0]  alucontrol,
  output logic [11:0] immediate,
  output logic        branch,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'b0000,
    DECODE   = 4'b0001,
    EXEC_R   = 4'b0101,
    EXEC_MEM = 4'b0110,
    EXEC_BR  = 4'b0111,
    MEM_RD   = 4'b1000,
    MEM_WR   = 4'b1001,
    WB       = 4'b1010,
    BR_RES   = 4'b1011,
    TRAP     = 4'b1111
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic        alusrc_q, alusrc_d;
  logic [3:0]  aluctl_q, aluctl_d;
  logic [11:0] imm_q, imm_d;
  logic        branch_q, branch_d;
  logic [15:0] instr_count_q, instr_count_d;

  logic        dec_legal;
  state_e      dec_exec;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Decode the instruction register into ALU controls and the execute state.
  always_comb begin
    dec_legal = 1'b0;
    dec_exec  = TRAP;
    alusrc_d  = 1'b0;
    aluctl_d  = '0;
    imm_d     = '0;
    branch_d  = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec_exec = EXEC_R;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              aluctl_d  = 4'b0010;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              aluctl_d  = 4'b0110;
            end
          end
          3'b111: begin
            dec_legal = 1'b1;
            aluctl_d  = 4'b0000;
          end
          3'b110: begin
            dec_legal = 1'b1;
            aluctl_d  = 4'b0001;
          end
          3'b100: begin
            dec_legal = 1'b1;
            aluctl_d  = 4'b0100;
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              aluctl_d  = 4'b0101;
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec_exec  = EXEC_R;
        dec_legal = (funct3 == 3'b000);
        alusrc_d  = 1'b1;
        aluctl_d  = 4'b0011;
        imm_d     = ir_q[31:20];
      end
      OP_LOAD: begin
        dec_exec  = EXEC_MEM;
        dec_legal = (funct3 == 3'b010);
        alusrc_d  = 1'b1;
        aluctl_d  = 4'b0010;
        imm_d     = ir_q[31:20];
      end
      OP_STOR: begin
        dec_exec  = EXEC_MEM;
        dec_legal = (funct3 == 3'b010);
        alusrc_d  = 1'b1;
        aluctl_d  = 4'b0010;
        imm_d     = {ir_q[31:25], ir_q[11:7]};
      end
      OP_BR: begin
        dec_exec  = EXEC_BR;
        dec_legal = (funct3 == 3'b000);
        alusrc_d  = 1'b1;
        aluctl_d  = 4'b0110;
        branch_d  = 1'b1;
        imm_d     = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state selection and Moore strobes for the current state.
  always_comb begin
    state_d  = state_q;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE:   state_d = dec_legal ? dec_exec : TRAP;
      EXEC_R:   state_d = WB;
      EXEC_MEM: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      EXEC_BR:  state_d = BR_RES;
      MEM_RD: begin
        memread = 1'b1;
        if (mem_ready) state_d = WB;
      end
      MEM_WR: begin
        memwrite = 1'b1;
        if (mem_ready) begin
          pcwrite = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        memtoreg = (opcode == OP_LOAD);
        state_d  = FETCH;
      end
      BR_RES: begin
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  assign instr_count_d = instr_count_q + 16'd1;

  // State register, instruction register, latched decode and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      ir_q          <= '0;
      alusrc_q      <= 1'b0;
      aluctl_q      <= '0;
      imm_q         <= '0;
      branch_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) ir_q <= instr_in;
      // Decode fields are captured only when leaving DECODE for an execute
      // state; a trapped instruction leaves the previous values in place.
      if (state_q == DECODE && dec_legal) begin
        alusrc_q <= alusrc_d;
        aluctl_q <= aluctl_d;
        imm_q    <= imm_d;
        branch_q <= branch_d;
      end
      if (pcwrite) instr_count_q <= instr_count_d;
    end
  end

  assign estado      = state_q;
  assign alusrc      = alusrc_q;
  assign alucontrol  = aluctl_q;
  assign immediate   = imm_q;
  assign branch      = branch_q;
  assign rs1         = ir_q[19:15];
  assign rs2         = ir_q[24:20];
  assign rd          = ir_q[11:7];
  assign instr_count = instr_count_q;

endmodule
